// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default line/frame sizing.
// Used by both the frame transmitter and the receive side.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // 50 MHz system clock / 9600 baud
    localparam int UART_BAUD_DIV_DEF  = 5208;
    localparam int UART_NUM_BYTES_DEF = 13;
    localparam int UART_DATA_BITS     = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time generator: while enabled, emits a one-cycle tick on the last clock
// of every BAUD_DIV-clock bit period. The count is held at zero while
// disabled, so every enable rising edge starts a fresh, full-length bit.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(BAUD_DIV - 1));
    assign o_tick = i_en & w_last;

    // Count clocks within the current bit; reload at each bit boundary
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Multi-byte 8N1 UART frame transmitter. Accepts a NUM_BYTES payload on a
// TxStart request while idle and sends it most-significant byte first, each
// byte LSB first, with no gaps between bytes. Txd comes straight from a flop.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = UART_BAUD_DIV_DEF,
    parameter int NUM_BYTES = UART_NUM_BYTES_DEF
) (
    input  logic                   Clk,
    input  logic                   RstN,
    input  logic                   TxStart,
    input  logic [8*NUM_BYTES-1:0] DataBuff,
    output logic                   Txd,
    output logic                   TxBusy,
    output logic                   TxDone
);

    localparam int FRAME_W = 8 * NUM_BYTES;
    localparam int BYTE_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    uart_state_e        r_state;
    uart_state_e        w_state_next;
    logic [FRAME_W-1:0] r_shreg;
    logic [2:0]         r_bit_cnt;
    logic [BYTE_W-1:0]  r_byte_cnt;
    logic               r_txd;
    logic               r_done;
    logic               w_txd_next;
    logic               w_done_next;
    logic               w_tick;
    logic               w_accept;
    logic               w_last_byte;
    logic               w_baud_en;
    logic [7:0]         w_cur_byte;
    logic [2:0]         w_bit_nxt;

    // The byte on the wire is always the top byte of the shift register
    assign w_cur_byte  = r_shreg[FRAME_W-1 -: 8];
    assign w_bit_nxt   = r_bit_cnt + 3'd1;
    assign w_last_byte = (r_byte_cnt == BYTE_W'(NUM_BYTES - 1));
    assign w_accept    = TxStart && (r_state == ST_IDLE);
    assign w_baud_en   = (r_state != ST_IDLE);

    assign Txd    = r_txd;
    assign TxBusy = (r_state != ST_IDLE);
    assign TxDone = r_done;

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .i_clk   (Clk),
        .i_rst_n (RstN),
        .i_en    (w_baud_en),
        .o_tick  (w_tick)
    );

    // State register
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: one bit time in START, eight in DATA, one in STOP
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_next = ST_START;
            ST_START: if (w_tick) w_state_next = ST_DATA;
            ST_DATA:  if (w_tick && (r_bit_cnt == 3'd7)) w_state_next = ST_STOP;
            ST_STOP:  if (w_tick) w_state_next = w_last_byte ? ST_IDLE : ST_START;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Output logic: line level and done pulse for the cycle after this edge
    always_comb begin
        w_txd_next  = r_txd;
        w_done_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_txd_next = w_accept ? 1'b0 : 1'b1;
            end
            ST_START: begin
                if (w_tick) w_txd_next = w_cur_byte[0];
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_txd_next = (r_bit_cnt == 3'd7) ? 1'b1 : w_cur_byte[w_bit_nxt];
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    w_txd_next  = w_last_byte ? 1'b1 : 1'b0;
                    w_done_next = w_last_byte;
                end
            end
            default: begin
                w_txd_next = 1'b1;
            end
        endcase
    end

    // Registered outputs so Txd has no combinational path from any input
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_txd  <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_txd  <= w_txd_next;
            r_done <= w_done_next;
        end
    end

    // Payload capture, byte shifting and bit/byte position counters
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt  <= '0;
                    r_byte_cnt <= '0;
                    if (w_accept) r_shreg <= DataBuff;
                end
                ST_DATA: begin
                    if (w_tick) r_bit_cnt <= w_bit_nxt;
                end
                ST_STOP: begin
                    if (w_tick && !w_last_byte) begin
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        r_shreg    <= r_shreg << 8;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx with a short bit time. The expected
// serial line is computed from the 8N1 framing rules, and a sampling receiver
// decodes the recorded line back into a payload.
module tb_uart_frame_tx;

    localparam int BAUD  = 4;
    localparam int NB    = 13;
    localparam int W     = 8 * NB;
    localparam int FRAME = NB * 10 * BAUD;
    localparam int REC   = 1100;

    logic         Clk = 1'b0;
    logic         RstN = 1'b0;
    logic         TxStart = 1'b0;
    logic [W-1:0] DataBuff = '0;
    logic         Txd;
    logic         TxBusy;
    logic         TxDone;

    int checks = 0;
    int failures = 0;

    logic tr_txd  [REC];
    logic tr_busy [REC];
    logic tr_done [REC];
    logic exp_line[FRAME];

    uart_frame_tx #(
        .BAUD_DIV  (BAUD),
        .NUM_BYTES (NB)
    ) dut (
        .Clk      (Clk),
        .RstN     (RstN),
        .TxStart  (TxStart),
        .DataBuff (DataBuff),
        .Txd      (Txd),
        .TxBusy   (TxBusy),
        .TxDone   (TxDone)
    );

    always #5 Clk = ~Clk;

    function automatic logic [W-1:0] rand_data();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    // Ideal line waveform for one frame: slot k carries byte NB-1-k,
    // each slot is start(0), 8 data bits LSB first, stop(1), BAUD clocks per bit.
    function automatic void build_expected(input logic [W-1:0] d);
        int bp, slot, pos;
        logic [7:0] by;
        for (int c = 0; c < FRAME; c++) begin
            bp   = c / BAUD;
            slot = bp / 10;
            pos  = bp % 10;
            by   = d[8*(NB-1-slot) +: 8];
            if (pos == 0)      exp_line[c] = 1'b0;
            else if (pos == 9) exp_line[c] = 1'b1;
            else               exp_line[c] = by[pos-1];
        end
    endfunction

    // Receiver: samples each data bit mid-period, first byte received is the top byte
    function automatic logic [W-1:0] decode(input int base);
        logic [W-1:0] r;
        r = '0;
        for (int s = 0; s < NB; s++)
            for (int j = 0; j < 8; j++)
                r[8*(NB-1-s) + j] = tr_txd[base + s*10*BAUD + (1+j)*BAUD + BAUD/2];
        return r;
    endfunction

    function automatic int line_errors(input int base, output int first);
        int n;
        n = 0;
        first = -1;
        for (int c = 0; c < FRAME; c++)
            if (tr_txd[base + c] !== exp_line[c]) begin
                if (first < 0) first = c;
                n++;
            end
        return n;
    endfunction

    function automatic int count_ones_busy(input int lo, input int hi);
        int n;
        n = 0;
        for (int i = lo; i <= hi; i++) if (tr_busy[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_ones_done(input int lo, input int hi);
        int n;
        n = 0;
        for (int i = lo; i <= hi; i++) if (tr_done[i] === 1'b1) n++;
        return n;
    endfunction

    // Issue one TxStart with payload d, then record ncyc cycles; index 0 is the
    // first cycle after the acceptance edge.
    task automatic capture(input logic [W-1:0] d, input int ncyc, input bit hold, input bit disturb);
        @(negedge Clk);
        DataBuff = d;
        TxStart  = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge Clk);
            tr_txd[i]  = Txd;
            tr_busy[i] = TxBusy;
            tr_done[i] = TxDone;
            if (!hold) TxStart = 1'b0;
            if (disturb) begin
                if (i == 10 || i == 100 || i == 300) TxStart = 1'b1;
                if (i == 50) DataBuff = '1;
            end
        end
        TxStart = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge Clk);
        RstN = 1'b0;
        @(negedge Clk);
        RstN = 1'b1;
    endtask

    task automatic test_reset();
        int bad;
        RstN = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if ({Txd, TxBusy, TxDone} !== 3'b100) begin
            failures++;
            $display("FAIL reset_outputs: Txd/Busy/Done=%b required 100", {Txd, TxBusy, TxDone});
        end
        RstN = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            DataBuff = rand_data();
            @(negedge Clk);
            if ({Txd, TxBusy, TxDone} !== 3'b100) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_quiet: %0d cycles left idle line/flags, required 0", bad);
        end
        RstN = 1'b0;
        @(negedge Clk);
        RstN    = 1'b1;
        TxStart = 1'b1;
        @(negedge Clk);
        TxStart = 1'b0;
        checks++;
        if ({Txd, TxBusy} !== 2'b01) begin
            failures++;
            $display("FAIL first_edge_accept: Txd/Busy=%b required 01", {Txd, TxBusy});
        end
        pulse_reset();
    endtask

    task automatic test_single_frame();
        logic [W-1:0] d;
        int n, first;
        d = 104'h0102030405060708090A0B0C0D;
        build_expected(d);
        capture(d, 530, 1'b0, 1'b0);
        checks++;
        if (tr_txd[0] !== 1'b0 || tr_busy[0] !== 1'b1) begin
            failures++;
            $display("FAIL single_latency: Txd=%b Busy=%b required 0 1", tr_txd[0], tr_busy[0]);
        end
        n = line_errors(0, first);
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL single_line: %0d wrong cycles (first at %0d), required 0", n, first);
        end
        checks++;
        if (decode(0) !== d) begin
            failures++;
            $display("FAIL single_decode: got %h required %h", decode(0), d);
        end
        n = count_ones_busy(0, 529);
        checks++;
        if (n != FRAME || tr_busy[FRAME-1] !== 1'b1) begin
            failures++;
            $display("FAIL single_busy_len: busy %0d cycles, required %0d", n, FRAME);
        end
        n = count_ones_done(0, 529);
        checks++;
        if (n != 1 || tr_done[FRAME] !== 1'b1 || tr_busy[FRAME] !== 1'b0) begin
            failures++;
            $display("FAIL single_done: %0d pulses, at-end done=%b busy=%b, required 1 pulse 1 0",
                     n, tr_done[FRAME], tr_busy[FRAME]);
        end
        n = 0;
        for (int i = FRAME; i < 530; i++) if (tr_txd[i] !== 1'b1) n++;
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL single_idle_after: %0d low cycles after frame, required 0", n);
        end
    endtask

    task automatic test_bit_timing();
        logic [W-1:0] d;
        logic [0:9] pat;
        int n;
        pat = 10'b0101001011;
        d = rand_data();
        d[W-1 -: 8] = 8'hA5;
        capture(d, 530, 1'b0, 1'b0);
        n = 0;
        for (int c = 0; c < 10*BAUD; c++) if (tr_txd[c] !== pat[c/BAUD]) n++;
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL bit_timing_a5: %0d wrong cycles in first slot, required 0", n);
        end
    endtask

    task automatic test_ignored_start();
        logic [W-1:0] d;
        int n, first;
        d = rand_data();
        build_expected(d);
        capture(d, 530, 1'b0, 1'b1);
        n = line_errors(0, first);
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL ignored_line: %0d wrong cycles (first at %0d), required 0", n, first);
        end
        n = count_ones_busy(0, 529);
        checks++;
        if (n != FRAME) begin
            failures++;
            $display("FAIL ignored_busy: busy %0d cycles, required %0d", n, FRAME);
        end
        n = count_ones_done(0, 529);
        checks++;
        if (n != 1 || tr_done[FRAME] !== 1'b1) begin
            failures++;
            $display("FAIL ignored_done: %0d pulses, done at end=%b, required 1 1", n, tr_done[FRAME]);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d;
        int n, first, n2;
        d = rand_data();
        build_expected(d);
        capture(d, 2*(FRAME+1) + 10, 1'b1, 1'b0);
        n  = line_errors(0, first);
        n2 = line_errors(FRAME + 1, first);
        checks++;
        if (n != 0 || n2 != 0) begin
            failures++;
            $display("FAIL b2b_lines: %0d and %0d wrong cycles, required 0 0", n, n2);
        end
        checks++;
        if (tr_done[FRAME] !== 1'b1 || tr_txd[FRAME] !== 1'b1 ||
            tr_txd[FRAME+1] !== 1'b0 || tr_busy[FRAME+1] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart: done=%b txd=%b next txd=%b busy=%b, required 1 1 0 1",
                     tr_done[FRAME], tr_txd[FRAME], tr_txd[FRAME+1], tr_busy[FRAME+1]);
        end
        n  = count_ones_done(0, 2*FRAME + 1);
        n2 = count_ones_busy(0, 2*FRAME + 1);
        checks++;
        if (n != 2 || tr_done[2*FRAME+1] !== 1'b1 || n2 != 2*FRAME) begin
            failures++;
            $display("FAIL b2b_period: done pulses %0d busy cycles %0d, required 2 %0d", n, n2, 2*FRAME);
        end
        pulse_reset();
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] d;
        int n, first, bad;
        d = rand_data();
        @(negedge Clk);
        DataBuff = d;
        TxStart  = 1'b1;
        @(negedge Clk);
        TxStart = 1'b0;
        repeat (137) @(negedge Clk);
        RstN = 1'b0;
        #1;
        checks++;
        if (Txd !== 1'b1 || TxBusy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_abort: Txd=%b Busy=%b required 1 0", Txd, TxBusy);
        end
        bad = 0;
        repeat (3) begin
            @(negedge Clk);
            if (TxDone !== 1'b0 || Txd !== 1'b1) bad++;
        end
        RstN = 1'b1;
        repeat (40) begin
            @(negedge Clk);
            if (TxDone !== 1'b0 || Txd !== 1'b1 || TxBusy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL midreset_quiet: %0d bad cycles after abort, required 0", bad);
        end
        d = rand_data();
        build_expected(d);
        capture(d, 530, 1'b0, 1'b0);
        n = line_errors(0, first);
        checks++;
        if (n != 0 || decode(0) !== d || count_ones_done(0, 529) != 1) begin
            failures++;
            $display("FAIL midreset_resend: %0d wrong cycles, decoded %h required %h", n, decode(0), d);
        end
    endtask

    task automatic test_random_frames();
        logic [W-1:0] d;
        int n, first;
        for (int k = 0; k < 4; k++) begin
            d = rand_data();
            build_expected(d);
            capture(d, 530, 1'b0, 1'b0);
            n = line_errors(0, first);
            checks++;
            if (n != 0 || decode(0) !== d) begin
                failures++;
                $display("FAIL random_frame_%0d: %0d wrong cycles, decoded %h required %h",
                         k, n, decode(0), d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_bit_timing();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
